// File: rtl/division_secuencial_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master side drives operands and start; the slave side returns results and status.
interface division_secuencial_if #(
  parameter int unsigned N = 4
);
  logic         init;
  logic [N-1:0] dv;
  logic [N-1:0] dr;
  logic [N-1:0] cociente;
  logic [N-1:0] residuo;
  logic         busy;
  logic         done;
  logic         dz;

  modport master (
    output init, dv, dr,
    input  cociente, residuo, busy, done, dz
  );

  modport slave (
    input  init, dv, dr,
    output cociente, residuo, busy, done, dz
  );
endinterface

// File: rtl/division_secuencial.sv
// Restoring divider: N shift/subtract iterations on one shared N+2-bit subtractor
// whose MSB is the borrow. A zero divisor completes at once with dz raised.
module division_secuencial #(
  parameter int unsigned N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  division_secuencial_if.slave  bus
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SUB,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N:0]     r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   cociente_q, cociente_d;
  logic [N-1:0]   residuo_q, residuo_d;
  logic           dz_q, dz_d;

  logic [N+1:0]   diff;
  logic           borrow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      cociente_q <= '0;
      residuo_q  <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      cociente_q <= cociente_d;
      residuo_q  <= residuo_d;
      dz_q       <= dz_d;
    end
  end

  assign diff   = {1'b0, r_q} - {2'b00, d_q};
  assign borrow = diff[N+1];

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    cociente_d = cociente_q;
    residuo_d  = residuo_q;
    dz_d       = dz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.init) begin
          if (bus.dr == '0) begin
            dz_d       = 1'b1;
            cociente_d = '1;
            residuo_d  = bus.dv;
            state_d    = DONE;
          end else begin
            r_d     = '0;
            q_d     = bus.dv;
            d_d     = bus.dr;
            cnt_d   = CW'(N);
            dz_d    = 1'b0;
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        {r_d, q_d} = {r_q, q_q} << 1;
        state_d    = SUB;
      end

      SUB: begin
        if (!borrow) begin
          r_d = diff[N:0];
          q_d = {q_q[N-1:1], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        // Results are taken from the next-state values so the final quotient bit is included.
        if (cnt_q == CW'(1)) begin
          cociente_d = {q_q[N-1:1], ~borrow};
          residuo_d  = borrow ? r_q[N-1:0] : diff[N-1:0];
          state_d    = DONE;
        end else begin
          state_d = SHIFT;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cociente = cociente_q;
  assign bus.residuo  = residuo_q;
  assign bus.dz       = dz_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);

endmodule
